// File: rtl/axis_pkg.sv
// ============================================================================
// Module      : axis_pkg
// Description : Shared types and helpers for the AXI-Stream burst checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_t;

    // Counter increment that sticks at max_v; callers narrower than 32 bits cast in and out.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_ready_throttle.sv
// ============================================================================
// Module      : axis_ready_throttle
// Description : Free-running period counter that masks tready one cycle per
//               READY_PERIOD while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_ready_throttle #(
    parameter int READY_PERIOD = 4
) (
    input  logic aclk,
    input  logic areset,
    input  logic clear,
    input  logic enable,
    output logic allow
);

    localparam int            CW   = $clog2(READY_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(READY_PERIOD - 1);

    logic [CW-1:0] thr_cnt_q;
    logic [CW-1:0] thr_cnt_d;

    always_comb begin
        thr_cnt_d = thr_cnt_q + CW'(1);
        if (clear || thr_cnt_q == LAST) begin
            thr_cnt_d = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            thr_cnt_q <= '0;
        end else begin
            thr_cnt_q <= thr_cnt_d;
        end
    end

    assign allow = !(enable && thr_cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/axis_burst_checker.sv
// ============================================================================
// Module      : axis_burst_checker
// Description : AXI-Stream sink that consumes a commanded burst and checks
//               each beat against an incrementing reference sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_burst_checker
    import axis_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int BURST_LEN_WIDTH = 16,
    parameter int READY_PERIOD    = 4
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       start,
    input  logic [BURST_LEN_WIDTH-1:0] burst_len,
    input  logic [AXI_DATA_WIDTH-1:0]  seed,
    input  logic                       throttle_en,
    input  logic [AXI_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       busy,
    output logic                       done,
    output logic                       err_flag,
    output logic [BURST_LEN_WIDTH-1:0] err_cnt,
    output logic [BURST_LEN_WIDTH-1:0] first_err_idx
);

    localparam logic [BURST_LEN_WIDTH-1:0] CNT_MAX = '1;

    chk_state_t                 state_q, state_d;
    logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
    logic                       throttle_en_q, throttle_en_d;
    logic [AXI_DATA_WIDTH-1:0]  expected_q, expected_d;
    logic [BURST_LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                       err_flag_q, err_flag_d;
    logic [BURST_LEN_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [BURST_LEN_WIDTH-1:0] first_err_idx_q, first_err_idx_d;

    logic thr_allow;
    logic beat_acc;

    axis_ready_throttle #(
        .READY_PERIOD (READY_PERIOD)
    ) u_throttle (
        .aclk   (aclk),
        .areset (areset),
        .clear  (state_q != ST_RUN),
        .enable (throttle_en_q),
        .allow  (thr_allow)
    );

    assign s_axis_tready = (state_q == ST_RUN) && thr_allow;
    assign beat_acc      = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        throttle_en_d   = throttle_en_q;
        expected_d      = expected_q;
        beat_cnt_d      = beat_cnt_q;
        err_flag_d      = err_flag_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_flag_d      = 1'b0;
                    err_cnt_d       = '0;
                    first_err_idx_d = '0;
                    if (burst_len != '0) begin
                        len_d         = burst_len;
                        throttle_en_d = throttle_en;
                        expected_d    = seed;
                        beat_cnt_d    = '0;
                        state_d       = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (beat_acc) begin
                    // err_flag_q still low means this is the burst's first mismatch
                    if (s_axis_tdata != expected_q) begin
                        err_flag_d = 1'b1;
                        err_cnt_d  = BURST_LEN_WIDTH'(sat_inc(32'(err_cnt_q), 32'(CNT_MAX)));
                        if (!err_flag_q) begin
                            first_err_idx_d = beat_cnt_q;
                        end
                    end
                    expected_d = expected_q + AXI_DATA_WIDTH'(1);
                    beat_cnt_d = beat_cnt_q + BURST_LEN_WIDTH'(1);
                    if (beat_cnt_q == len_q - BURST_LEN_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q         <= ST_IDLE;
            len_q           <= '0;
            throttle_en_q   <= 1'b0;
            expected_q      <= '0;
            beat_cnt_q      <= '0;
            err_flag_q      <= 1'b0;
            err_cnt_q       <= '0;
            first_err_idx_q <= '0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            throttle_en_q   <= throttle_en_d;
            expected_q      <= expected_d;
            beat_cnt_q      <= beat_cnt_d;
            err_flag_q      <= err_flag_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
        end
    end

    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign err_flag      = err_flag_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_burst_checker.sv
// ============================================================================
// Module      : tb_axis_burst_checker
// Description : Directed self-checking bench for axis_burst_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_burst_checker;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] burst_len = '0;
    logic [31:0] seed = '0;
    logic        throttle_en = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        busy;
    logic        done;
    logic        err_flag;
    logic [15:0] err_cnt;
    logic [15:0] first_err_idx;

    int checks = 0;
    int failures = 0;

    logic [31:0] src [0:15];

    always #5 aclk = ~aclk;

    axis_burst_checker #(
        .AXI_DATA_WIDTH  (32),
        .BURST_LEN_WIDTH (16),
        .READY_PERIOD    (4)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .burst_len     (burst_len),
        .seed          (seed),
        .throttle_en   (throttle_en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .busy          (busy),
        .done          (done),
        .err_flag      (err_flag),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    // Issues a one-cycle start; returns at the negedge where the new state is visible.
    task automatic do_start(input logic [15:0] len, input logic [31:0] sd, input logic thr);
        @(negedge aclk);
        start       = 1'b1;
        burst_len   = len;
        seed        = sd;
        throttle_en = thr;
        @(negedge aclk);
        start = 1'b0;
    endtask

    // Stream source: presents src[] in order, advancing on each handshake, until done or budget.
    task automatic pump(input int n, input bit hold_valid, input int budget,
                        output int run_cycles, output int accepted, output int low_cycles,
                        output int first_low, output int done_gap, output bit saw_done);
        int idx;
        int cyc;
        int last_acc;
        idx = 0; cyc = 0; last_acc = -1;
        run_cycles = 0; accepted = 0; low_cycles = 0; first_low = -1; done_gap = -1; saw_done = 1'b0;
        while (!saw_done && cyc < budget) begin
            if (done) begin
                saw_done = 1'b1;
                done_gap = cyc - last_acc;
            end else begin
                s_axis_tvalid = hold_valid || (idx < n);
                s_axis_tdata  = src[(idx < 16) ? idx : 15];
                #1;
                if (busy) run_cycles++;
                if (busy && !s_axis_tready) begin
                    low_cycles++;
                    if (first_low < 0) first_low = run_cycles - 1;
                end
                if (s_axis_tvalid && s_axis_tready) begin
                    idx++;
                    accepted++;
                    last_acc = cyc;
                end
                cyc++;
                @(negedge aclk);
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        checks++;
        if ({s_axis_tready, busy, done, err_flag} !== 4'b0000 || err_cnt !== 16'd0 || first_err_idx !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs got tready=%b busy=%b done=%b flag=%b cnt=%0d idx=%0d required all zero",
                     s_axis_tready, busy, done, err_flag, err_cnt, first_err_idx);
        end
        areset = 1'b0;
    endtask

    task automatic test_basic();
        int rc, acc, low, fl, gap;
        bit sd;
        for (int i = 0; i < 4; i++) src[i] = 32'h10 + 32'(i);
        do_start(16'd4, 32'h10, 1'b0);
        pump(4, 1'b0, 40, rc, acc, low, fl, gap, sd);
        checks++;
        if (!sd || acc != 4 || rc != 4 || gap != 1) begin
            failures++;
            $display("FAIL basic_timing got done=%0d beats=%0d run=%0d gap=%0d required 1/4/4/1", sd, acc, rc, gap);
        end
        checks++;
        if (err_cnt !== 16'd0 || err_flag !== 1'b0) begin
            failures++;
            $display("FAIL basic_errors got cnt=%0d flag=%b required 0/0", err_cnt, err_flag);
        end
        @(negedge aclk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_error();
        int rc, acc, low, fl, gap;
        bit sd;
        for (int i = 0; i < 8; i++) src[i] = 32'(i);
        src[3] = 32'hFF;
        do_start(16'd8, 32'h0, 1'b0);
        pump(8, 1'b0, 60, rc, acc, low, fl, gap, sd);
        checks++;
        if (!sd || acc != 8) begin
            failures++;
            $display("FAIL error_beats got done=%0d beats=%0d required 1/8", sd, acc);
        end
        checks++;
        if (err_cnt !== 16'd1 || err_flag !== 1'b1 || first_err_idx !== 16'd3) begin
            failures++;
            $display("FAIL error_stats got cnt=%0d flag=%b idx=%0d required 1/1/3", err_cnt, err_flag, first_err_idx);
        end
        repeat (3) @(negedge aclk);
        checks++;
        if (err_cnt !== 16'd1 || err_flag !== 1'b1 || first_err_idx !== 16'd3) begin
            failures++;
            $display("FAIL error_hold got cnt=%0d flag=%b idx=%0d required 1/1/3", err_cnt, err_flag, first_err_idx);
        end
    endtask

    task automatic test_zero_len();
        do_start(16'd0, 32'h0, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || s_axis_tready !== 1'b0 || err_cnt !== 16'd0 || err_flag !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_done got done=%b busy=%b tready=%b cnt=%0d flag=%b required 1/0/0/0/0",
                     done, busy, s_axis_tready, err_cnt, err_flag);
        end
        @(negedge aclk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_after got done=%b busy=%b tready=%b required 0/0/0", done, busy, s_axis_tready);
        end
    endtask

    task automatic test_throttle();
        int rc, acc, low, fl, gap;
        bit sd;
        for (int i = 0; i < 16; i++) src[i] = 32'h20 + 32'(i);
        do_start(16'd8, 32'h20, 1'b1);
        pump(8, 1'b1, 60, rc, acc, low, fl, gap, sd);
        checks++;
        if (!sd || acc != 8 || rc != 10 || gap != 1) begin
            failures++;
            $display("FAIL throttle_rate got done=%0d beats=%0d run=%0d gap=%0d required 1/8/10/1", sd, acc, rc, gap);
        end
        checks++;
        if (low != 2 || fl != 3) begin
            failures++;
            $display("FAIL throttle_pattern got low=%0d first_low=%0d required 2/3", low, fl);
        end
        checks++;
        if (err_cnt !== 16'd0 || err_flag !== 1'b0) begin
            failures++;
            $display("FAIL throttle_errors got cnt=%0d flag=%b required 0/0", err_cnt, err_flag);
        end
    endtask

    task automatic test_wrap();
        int rc, acc, low, fl, gap;
        bit sd;
        src[0] = 32'hFFFF_FFFE; src[1] = 32'hFFFF_FFFF; src[2] = 32'h0; src[3] = 32'h1;
        do_start(16'd4, 32'hFFFF_FFFE, 1'b0);
        pump(4, 1'b0, 40, rc, acc, low, fl, gap, sd);
        checks++;
        if (!sd || acc != 4 || err_cnt !== 16'd0 || err_flag !== 1'b0) begin
            failures++;
            $display("FAIL wrap got done=%0d beats=%0d cnt=%0d flag=%b required 1/4/0/0", sd, acc, err_cnt, err_flag);
        end
    endtask

    task automatic test_reset_abort();
        int rc, acc, low, fl, gap, dcount;
        bit sd;
        do_start(16'd8, 32'h100, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h100;
        @(negedge aclk);
        s_axis_tdata  = 32'hBAD;
        @(negedge aclk);
        checks++;
        if (err_cnt !== 16'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre got cnt=%0d busy=%b required 1/1", err_cnt, busy);
        end
        areset = 1'b1;
        s_axis_tdata = 32'h102;
        @(negedge aclk);
        checks++;
        if (s_axis_tready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_flag !== 1'b0 ||
            err_cnt !== 16'd0 || first_err_idx !== 16'd0) begin
            failures++;
            $display("FAIL abort_reset got tready=%b busy=%b done=%b flag=%b cnt=%0d idx=%0d required all zero",
                     s_axis_tready, busy, done, err_flag, err_cnt, first_err_idx);
        end
        areset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            if (done || busy) dcount++;
        end
        s_axis_tvalid = 1'b0;
        checks++;
        if (dcount != 0) begin
            failures++;
            $display("FAIL abort_no_done got active_cycles=%0d required 0", dcount);
        end
        src[0] = 32'h5; src[1] = 32'h6;
        do_start(16'd2, 32'h5, 1'b0);
        pump(2, 1'b0, 30, rc, acc, low, fl, gap, sd);
        checks++;
        if (!sd || acc != 2 || rc != 2 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL abort_restart got done=%0d beats=%0d run=%0d cnt=%0d required 1/2/2/0", sd, acc, rc, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_zero_len();
        test_throttle();
        test_wrap();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
